// File: rtl/uart_rx_sipo.sv
// UART receiver: synchronises and oversamples the serial line, deserialises
// each frame LSB first, and holds the word behind a one-entry valid/ready buffer.
module uart_rx_sipo #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e               state_q,    state_d;
  logic [CNT_W-1:0]     cnt_q,      cnt_d;
  logic [IDX_W-1:0]     bitidx_q,   bitidx_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic [DATA_BITS-1:0] rx_data_q,  rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q,  overrun_d;
  logic                 busy_q,     busy_d;
  logic                 rx_meta_q,  rx_meta_d;
  logic                 rx_s_q,     rx_s_d;
  logic                 rx_s_dly_q, rx_s_dly_d;
  logic                 frame_good;

  // Two-flop synchroniser plus one extra stage for start-edge detection.
  always_comb begin
    rx_meta_d  = rx;
    rx_s_d     = rx_meta_q;
    rx_s_dly_d = rx_s_q;
  end

  // Bit-timing FSM, deserialiser and holding-register handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitidx_d    = bitidx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    frame_good  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_s_dly_q && !rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d    = '0;
          bitidx_d = '0;
          state_d  = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_END) begin
          cnt_d    = '0;
          shift_d  = DATA_BITS'({rx_s_q, shift_q} >> 1);
          bitidx_d = bitidx_q + IDX_W'(1);
          if (bitidx_q == IDX_LAST) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_s_q) begin
            frame_good = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A completing frame may refill the buffer in the same cycle it is consumed.
    if (frame_good) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bitidx_q    <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_s_dly_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitidx_q    <= bitidx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      rx_s_dly_q  <= rx_s_dly_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule
